// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared definitions for the 9-puzzle ALU and its instruction sequencer.
// Holds ALU and controller opcodes, the sequencer state enum, the instruction
// word layout (packed struct plus field positions) and small decode helpers.
package puzzle_pkg;

    localparam int unsigned DW   = 8;   // datapath / register width
    localparam int unsigned IW   = 24;  // instruction word width
    localparam int unsigned NREG = 8;   // register file depth
    localparam int unsigned RAW  = 3;   // register address width

    // Instruction field positions
    localparam int unsigned OP_LSB     = 16;
    localparam int unsigned IMMSEL_BIT = 15;
    localparam int unsigned DST_LSB    = 12;
    localparam int unsigned SRC_LSB    = 8;
    localparam int unsigned IMM_LSB    = 0;

    // ALU opcodes
    localparam logic [7:0] ALU_SET    = 8'h01;  // out = ina
    localparam logic [7:0] ALU_ADD    = 8'h02;  // out = ina + inb
    localparam logic [7:0] ALU_CHECK  = 8'h10;  // zf = (ina == inb)
    localparam logic [7:0] ALU_CHECKR = 8'h11;  // zf = (ina == inb), register form
    localparam logic [7:0] ALU_LESS   = 8'h12;  // zf = (inb < ina)
    localparam logic [7:0] ALU_WRITE  = 8'h20;  // out = inb, routed to board output

    // Controller opcodes, executed by the sequencer itself
    localparam logic [7:0] OP_NOP  = 8'hF0;
    localparam logic [7:0] OP_JMP  = 8'hF1;
    localparam logic [7:0] OP_JZ   = 8'hF2;
    localparam logic [7:0] OP_JNZ  = 8'hF3;
    localparam logic [7:0] OP_HALT = 8'hF4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_OUT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] op;
        logic       immsel;
        logic [2:0] dst;
        logic       rsvd;
        logic [2:0] src;
        logic [7:0] imm;
    } instr_t;

    function automatic logic is_ctrl_op(input logic [7:0] op);
        return op inside {OP_NOP, OP_JMP, OP_JZ, OP_JNZ, OP_HALT};
    endfunction

    function automatic logic is_cmp_op(input logic [7:0] op);
        return op inside {ALU_CHECK, ALU_CHECKR, ALU_LESS};
    endfunction

    // Assemble an instruction word; the reserved bit is left 0.
    function automatic logic [IW-1:0] mk_instr(input logic [7:0] op,
                                               input logic       immsel,
                                               input logic [2:0] dst,
                                               input logic [2:0] src,
                                               input logic [7:0] imm);
        logic [IW-1:0] w;
        w                  = '0;
        w[OP_LSB +: 8]     = op;
        w[IMMSEL_BIT]      = immsel;
        w[DST_LSB +: RAW]  = dst;
        w[SRC_LSB +: RAW]  = src;
        w[IMM_LSB +: DW]   = imm;
        return w;
    endfunction

endpackage

// File: rtl/puzzle_ctrl_if.sv
// puzzle_ctrl_if: bus bundle between the sequencer and its neighbours.
//   imem_addr/imem_rdata : synchronous instruction ROM (data one cycle after addr)
//   alu_ina/inb/op, alu_out/alu_zf : combinational 9-puzzle ALU
//   wr_valid/wr_data/wr_ready : board-output stream handshake
// master = sequencer side, slave = ROM/ALU/consumer side.
interface puzzle_ctrl_if #(
    parameter int unsigned IMEM_AW = 8
);
    import puzzle_pkg::*;

    logic [IMEM_AW-1:0] imem_addr;
    logic [IW-1:0]      imem_rdata;
    logic [DW-1:0]      alu_ina;
    logic [DW-1:0]      alu_inb;
    logic [DW-1:0]      alu_op;
    logic [DW-1:0]      alu_out;
    logic               alu_zf;
    logic               wr_valid;
    logic [DW-1:0]      wr_data;
    logic               wr_ready;

    modport master (
        output imem_addr, alu_ina, alu_inb, alu_op, wr_valid, wr_data,
        input  imem_rdata, alu_out, alu_zf, wr_ready
    );

    modport slave (
        input  imem_addr, alu_ina, alu_inb, alu_op, wr_valid, wr_data,
        output imem_rdata, alu_out, alu_zf, wr_ready
    );

endinterface

// File: rtl/puzzle_regfile.sv
// puzzle_regfile: 8 x 8-bit register file.
//   ra_addr/ra_data, rb_addr/rb_data : combinational operand read ports
//   dbg_addr/dbg_data                : combinational debug read port
//   we/waddr/wdata                   : synchronous write port
// Async active-low reset clears every register.
module puzzle_regfile
    import puzzle_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RAW-1:0] ra_addr,
    output logic [DW-1:0]  ra_data,
    input  logic [RAW-1:0] rb_addr,
    output logic [DW-1:0]  rb_data,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata
);

    logic [NREG-1:0][DW-1:0] regs_q;

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/puzzle_ctrl.sv
// puzzle_ctrl: multicycle instruction sequencer in front of the 9-puzzle ALU.
// Fetches from a synchronous ROM, decodes into ALU operands, writes results back
// to an 8-entry register file, runs JMP/JZ/JNZ/HALT itself and streams WRITE
// results over a valid/ready handshake.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   step              : single-step enable (only with PUZZLE_CTRL_STEP_EN defined)
//   start             : pulse, starts execution at PC 0 when idle
//   bus (master)      : ROM, ALU and write-stream signals
//   busy, done        : running flag, one-cycle completion pulse
//   dbg_addr/dbg_data : combinational register read-back
// Build option: PUZZLE_CTRL_STEP_EN adds the step port; FETCH then waits for step.
module puzzle_ctrl
    import puzzle_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef PUZZLE_CTRL_STEP_EN
    input  logic           step,
`endif
    input  logic           start,
    puzzle_ctrl_if.master  bus,
    output logic           busy,
    output logic           done,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data
);

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d, pc_inc, pc_tgt;
    logic               zf_q, zf_d;
    instr_t             ir_q, ir_d;
    instr_t             dec;
    logic [DW-1:0]      alu_ina_q, alu_ina_d;
    logic [DW-1:0]      alu_inb_q, alu_inb_d;
    logic [DW-1:0]      alu_op_q, alu_op_d;
    logic               wr_valid_q, wr_valid_d;
    logic [DW-1:0]      wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rf_we_c;
    logic [DW-1:0]      ra_data, rb_data;
    logic               step_ok;
    logic               ir_unused;

`ifdef PUZZLE_CTRL_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign dec    = instr_t'(bus.imem_rdata);
    assign pc_inc = pc_q + IMEM_AW'(1);
    assign pc_tgt = IMEM_AW'(ir_q.imm);

    // Operands are read straight off the ROM word during DECODE
    puzzle_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (dec.src),
        .ra_data  (ra_data),
        .rb_addr  (dec.dst),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we_c),
        .waddr    (ir_q.dst),
        .wdata    (bus.alu_out)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            zf_q       <= 1'b0;
            ir_q       <= '0;
            alu_ina_q  <= '0;
            alu_inb_q  <= '0;
            alu_op_q   <= OP_NOP;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            zf_q       <= zf_d;
            ir_q       <= ir_d;
            alu_ina_q  <= alu_ina_d;
            alu_inb_q  <= alu_inb_d;
            alu_op_q   <= alu_op_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, commit and output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        zf_d       = zf_q;
        ir_d       = ir_q;
        alu_ina_d  = alu_ina_q;
        alu_inb_d  = alu_inb_q;
        alu_op_d   = alu_op_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        rf_we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    zf_d    = 1'b0;
                end
            end
            ST_FETCH: begin
                if (step_ok) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ir_d      = dec;
                alu_ina_d = dec.immsel ? dec.imm : ra_data;
                alu_inb_d = rb_data;
                alu_op_d  = is_ctrl_op(dec.op) ? OP_NOP : dec.op;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (is_ctrl_op(ir_q.op)) begin
                    case (ir_q.op)
                        OP_JMP:  pc_d = pc_tgt;
                        OP_JZ:   if (zf_q)  pc_d = pc_tgt;
                        OP_JNZ:  if (!zf_q) pc_d = pc_tgt;
                        OP_HALT: begin
                            pc_d    = pc_q;
                            state_d = ST_DONE;
                        end
                        default: ;
                    endcase
                end else if (is_cmp_op(ir_q.op)) begin
                    zf_d = bus.alu_zf;
                end else if (ir_q.op == ALU_WRITE) begin
                    // PC stays on the WRITE until the consumer takes the beat
                    pc_d       = pc_q;
                    wr_data_d  = bus.alu_out;
                    wr_valid_d = 1'b1;
                    state_d    = ST_OUT;
                end else begin
                    rf_we_c = 1'b1;
                end
            end
            ST_OUT: begin
                if (wr_valid_q && bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    pc_d       = pc_inc;
                    state_d    = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_d inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_OUT};
        done_d = (state_d == ST_DONE);
    end

    assign bus.imem_addr = pc_q;
    assign bus.alu_ina   = alu_ina_q;
    assign bus.alu_inb   = alu_inb_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Operand-only fields are consumed in DECODE, not from the held word
    assign ir_unused = ^{ir_q.immsel, ir_q.rsvd, ir_q.src};

endmodule

// File: tb/tb_puzzle_ctrl.sv
module tb_puzzle_ctrl;
    import puzzle_pkg::*;

    localparam int unsigned AW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;
`ifdef PUZZLE_CTRL_STEP_EN
    logic       step = 1'b1;
`endif

    logic [23:0]   rom [256];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    obs_q [$];
    int            obs_rd = 0;
    logic [AW-1:0] trace [$];

    puzzle_ctrl_if #(.IMEM_AW(AW)) bus ();

    puzzle_ctrl #(.IMEM_AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef PUZZLE_CTRL_STEP_EN
        .step     (step),
`endif
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #10 clk = ~clk;

    // Synchronous ROM
    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    // Reference ALU
    always_comb begin
        bus.alu_out = 8'h00;
        bus.alu_zf  = 1'b0;
        case (bus.alu_op)
            ALU_SET:               bus.alu_out = bus.alu_ina;
            ALU_ADD:               bus.alu_out = bus.alu_ina + bus.alu_inb;
            ALU_WRITE:             bus.alu_out = bus.alu_inb;
            ALU_CHECK, ALU_CHECKR: bus.alu_zf  = (bus.alu_ina == bus.alu_inb);
            ALU_LESS:              bus.alu_zf  = (bus.alu_inb < bus.alu_ina);
            default: ;
        endcase
    end

    // Capture accepted write beats and the fetch address trace
    always @(negedge clk) begin
        if (rst_n && bus.wr_valid && bus.wr_ready) obs_q.push_back(bus.wr_data);
        if (busy && (trace.size() == 0 || trace[trace.size()-1] != bus.imem_addr))
            trace.push_back(bus.imem_addr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) rom[i] = mk_instr(OP_HALT, 1'b0, 3'd0, 3'd0, 8'd0);
    endtask

    task automatic load_write_prog();
        load_default();
        rom[0] = mk_instr(ALU_SET,   1'b1, 3'd1, 3'd0, 8'd5);
        rom[1] = mk_instr(ALU_ADD,   1'b1, 3'd1, 3'd0, 8'd3);
        rom[2] = mk_instr(ALU_WRITE, 1'b0, 3'd1, 3'd0, 8'd0);
    endtask

    task automatic run_prog(input int repulse, output int nbusy, output bit got);
        start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            start = (i == repulse);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [42:0] got_v, exp_v;
        rst_n = 1'b0;
        bus.wr_ready = 1'b0;
        tick();
        tick();
        got_v = {bus.imem_addr, bus.alu_ina, bus.alu_inb, bus.alu_op, bus.wr_valid,
                 bus.wr_data, busy, done};
        exp_v = {8'h00, 8'h00, 8'h00, OP_NOP, 1'b0, 8'h00, 1'b0, 1'b0};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got_v, exp_v);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_tests++;
            if (dbg_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg R%0d: got %h expected 00", i, dbg_data);
            end
        end
    endtask

    task automatic test_basic(input int repulse);
        int nb;
        bit got;
        logic [7:0] e;
        do_reset();
        load_write_prog();
        rom[3] = mk_instr(OP_HALT, 1'b0, 3'd0, 3'd0, 8'd0);
        bus.wr_ready = 1'b1;
        exp_q.push_back(8'd8);
        run_prog(repulse, nb, got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL basic_done(%0d): done not seen", repulse);
        end
        n_tests++;
        if (nb != 13) begin
            n_fail++;
            $display("FAIL basic_busy_cycles(%0d): got %0d expected 13", repulse, nb);
        end
        tick();
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_done_pulse(%0d): done/busy got %b expected 00", repulse, {done, busy});
        end
        dbg_addr = 3'd1;
        #1;
        n_tests++;
        if (dbg_data !== 8'd8) begin
            n_fail++;
            $display("FAIL basic_R1(%0d): got %0d expected 8", repulse, dbg_data);
        end
        repeat (4) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle(%0d): busy got %b expected 0", repulse, busy);
        end
        n_tests++;
        if (obs_q.size() - obs_rd != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_beats(%0d): got %0d expected %0d", repulse, obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q[obs_rd] !== e) begin
                n_fail++;
                $display("FAIL basic_wr_data(%0d): got %h expected %h", repulse, obs_q[obs_rd], e);
            end
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic test_branch(input logic [7:0] cmp_imm, input bit taken);
        int nb;
        bit got;
        int base;
        logic [AW-1:0] exp_tr [$];
        do_reset();
        load_default();
        rom[0] = mk_instr(ALU_SET,   1'b1, 3'd2, 3'd0, 8'd7);
        rom[1] = mk_instr(ALU_CHECK, 1'b1, 3'd2, 3'd0, cmp_imm);
        rom[2] = mk_instr(OP_JZ,     1'b0, 3'd0, 3'd0, 8'd8);
        rom[3] = mk_instr(ALU_SET,   1'b1, 3'd3, 3'd0, 8'd1);
        rom[8] = mk_instr(ALU_SET,   1'b1, 3'd3, 3'd0, 8'd2);
        if (taken) exp_tr = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9};
        else       exp_tr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        bus.wr_ready = 1'b1;
        base = trace.size();
        run_prog(-1, nb, got);
        n_tests++;
        if (!got || nb != 15) begin
            n_fail++;
            $display("FAIL branch_run(taken=%0b): done %0b busy cycles %0d expected 1/15", taken, got, nb);
        end
        n_tests++;
        if (trace.size() - base != exp_tr.size()) begin
            n_fail++;
            $display("FAIL branch_trace_len(taken=%0b): got %0d expected %0d", taken, trace.size() - base, exp_tr.size());
        end else begin
            for (int i = 0; i < exp_tr.size(); i++) begin
                n_tests++;
                if (trace[base+i] !== exp_tr[i]) begin
                    n_fail++;
                    $display("FAIL branch_fetch[%0d](taken=%0b): got %0d expected %0d", i, taken, trace[base+i], exp_tr[i]);
                end
            end
        end
        dbg_addr = 3'd3;
        #1;
        n_tests++;
        if (dbg_data !== (taken ? 8'd2 : 8'd1)) begin
            n_fail++;
            $display("FAIL branch_R3(taken=%0b): got %0d expected %0d", taken, dbg_data, taken ? 2 : 1);
        end
    endtask

    task automatic test_wrap();
        int nb;
        bit got;
        int base;
        logic [AW-1:0] exp_tr [$];
        do_reset();
        load_default();
        rom[0]   = mk_instr(ALU_ADD,   1'b1, 3'd1, 3'd0, 8'd1);
        rom[1]   = mk_instr(ALU_CHECK, 1'b1, 3'd1, 3'd0, 8'd2);
        rom[2]   = mk_instr(OP_JZ,     1'b0, 3'd0, 3'd0, 8'd10);
        rom[3]   = mk_instr(ALU_SET,   1'b1, 3'd0, 3'd0, 8'd250);
        rom[4]   = mk_instr(ALU_ADD,   1'b1, 3'd0, 3'd0, 8'd10);
        rom[5]   = mk_instr(OP_JMP,    1'b0, 3'd0, 3'd0, 8'd255);
        rom[255] = mk_instr(OP_NOP,    1'b0, 3'd0, 3'd0, 8'd0);
        exp_tr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255, 8'd0, 8'd1, 8'd2, 8'd10};
        base = trace.size();
        run_prog(-1, nb, got);
        n_tests++;
        if (!got || nb != 33) begin
            n_fail++;
            $display("FAIL wrap_run: done %0b busy cycles %0d expected 1/33", got, nb);
        end
        n_tests++;
        if (trace.size() - base != exp_tr.size()) begin
            n_fail++;
            $display("FAIL wrap_trace_len: got %0d expected %0d", trace.size() - base, exp_tr.size());
        end else begin
            for (int i = 0; i < exp_tr.size(); i++) begin
                n_tests++;
                if (trace[base+i] !== exp_tr[i]) begin
                    n_fail++;
                    $display("FAIL wrap_fetch[%0d]: got %0d expected %0d", i, trace[base+i], exp_tr[i]);
                end
            end
        end
        dbg_addr = 3'd0;
        #1;
        n_tests++;
        if (dbg_data !== 8'd4) begin
            n_fail++;
            $display("FAIL wrap_R0: got %0d expected 4", dbg_data);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        int cnt;
        logic [7:0] e;
        do_reset();
        load_default();
        rom[0] = mk_instr(ALU_SET,   1'b1, 3'd4, 3'd0, 8'h5A);
        rom[1] = mk_instr(ALU_WRITE, 1'b0, 3'd4, 3'd0, 8'd0);
        bus.wr_ready = 1'b0;
        exp_q.push_back(8'h5A);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (bus.wr_valid !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_tests++;
        if (bus.wr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid: wr_valid got %b expected 1 within 50 cycles", bus.wr_valid);
        end
        cnt = 0;
        while (bus.wr_valid === 1'b1 && cnt < 50) begin
            cnt++;
            n_tests++;
            if (bus.wr_data !== 8'h5A || bus.imem_addr !== 8'd1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: data/pc got %h/%0d expected 5a/1", cnt, bus.wr_data, bus.imem_addr);
            end
            if (cnt == 6) bus.wr_ready = 1'b1;
            tick();
        end
        n_tests++;
        if (cnt != 6 || bus.imem_addr !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_handshake: valid cycles/pc got %0d/%0d expected 6/2", cnt, bus.imem_addr);
        end
        guard = 0;
        while (done !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: done got %b expected 1", done);
        end
        n_tests++;
        if (obs_q.size() - obs_rd != 1) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d expected 1", obs_q.size() - obs_rd);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q[obs_rd] !== e) begin
                n_fail++;
                $display("FAIL bp_wr_data: got %h expected %h", obs_q[obs_rd], e);
            end
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_in_out();
        int guard;
        int nb;
        bit got;
        int base;
        do_reset();
        load_default();
        rom[0] = mk_instr(ALU_SET,   1'b1, 3'd4, 3'd0, 8'h5A);
        rom[1] = mk_instr(ALU_WRITE, 1'b0, 3'd4, 3'd0, 8'd0);
        bus.wr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (bus.wr_valid !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_tests++;
        if (bus.wr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rio_reach_out: wr_valid got %b expected 1", bus.wr_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.wr_valid, busy, bus.imem_addr} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rio_async: valid/busy/pc got %b/%b/%0d expected 0/0/0", bus.wr_valid, busy, bus.imem_addr);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_tests++;
            if (dbg_data !== 8'h00) begin
                n_fail++;
                $display("FAIL rio_reg R%0d: got %h expected 00", i, dbg_data);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.wr_ready = 1'b1;
        obs_rd = obs_q.size();
        base = trace.size();
        run_prog(-1, nb, got);
        n_tests++;
        if (!got || nb != 10) begin
            n_fail++;
            $display("FAIL rio_rerun: done %0b busy cycles %0d expected 1/10", got, nb);
        end
        n_tests++;
        if (trace.size() - base != 3 || trace[base] !== 8'd0) begin
            n_fail++;
            $display("FAIL rio_trace: length %0d first %0d expected 3 from 0", trace.size() - base, trace[base]);
        end
        n_tests++;
        if (obs_q.size() - obs_rd != 1 || obs_q[obs_q.size()-1] !== 8'h5A) begin
            n_fail++;
            $display("FAIL rio_beat: count %0d expected 1 of 5a", obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

`ifdef PUZZLE_CTRL_STEP_EN
    task automatic test_step();
        int guard;
        do_reset();
        load_write_prog();
        bus.wr_ready = 1'b1;
        step = 1'b0;
        obs_rd = obs_q.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (bus.imem_addr !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL step_frozen: pc/busy got %0d/%b expected 0/1", bus.imem_addr, busy);
        end
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (8) tick();
        end
        dbg_addr = 3'd1;
        #1;
        n_tests++;
        if (bus.imem_addr !== 8'd3 || dbg_data !== 8'd8 || obs_q.size() - obs_rd != 1) begin
            n_fail++;
            $display("FAIL step_three: pc/R1/beats got %0d/%0d/%0d expected 3/8/1", bus.imem_addr, dbg_data, obs_q.size() - obs_rd);
        end
        step = 1'b1;
        guard = 0;
        while (done !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL step_done: done got %b expected 1", done);
        end
        obs_rd = obs_q.size();
    endtask
`endif

    initial begin
        test_reset();
        test_basic(-1);
        test_branch(8'd7, 1'b1);
        test_branch(8'd6, 1'b0);
        test_wrap();
        test_backpressure();
        test_reset_in_out();
        test_basic(4);
`ifdef PUZZLE_CTRL_STEP_EN
        test_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
